adc_sample_capture: RTL

- Sink at the far end of the ADC sample path. Takes multichannel samples, e.g. the FIR output stream.
- After a CPU-armed trigger, writes a fixed-length window into an internal RAM. The CPU reads the RAM back through a simple registered read port, which the intbus register wrapper maps.
- Used to inspect filter impulse and step responses in hardware.

---
 rtl/adc_sample_capture.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_capture.sv
// Triggered multichannel sample capture into an internal RAM with a registered CPU read port.
// Define ADC_CAPTURE_PRETRIG_EN to add pre-trigger circular buffering (pretrig in, trig_addr out).
module adc_sample_capture #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned R          = 14,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    input  logic [NCH*R-1:0]                          in_data,
    input  logic                                      arm,
    input  logic                                      abort,
    input  logic                                      force_trig,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  trig_ch,
    input  logic signed [R-1:0]                       trig_level,
    input  logic [DEPTH_LOG2:0]                       n_samples,
    input  logic                                      rd_en,
    input  logic [DEPTH_LOG2-1:0]                     rd_addr,
    output logic [NCH*R-1:0]                          rd_data,
    output logic                                      rd_valid,
    output logic [1:0]                                state,
    output logic [DEPTH_LOG2:0]                       wr_count
`ifdef ADC_CAPTURE_PRETRIG_EN
    ,
    input  logic [DEPTH_LOG2-1:0]                     pretrig,
    output logic [DEPTH_LOG2-1:0]                     trig_addr
`endif
);

    localparam int unsigned W     = NCH * R;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned TCH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          wr_count_q, wr_count_d;
    logic [CW-1:0]          n_lat_q, n_lat_d;
    logic [TCH_W-1:0]       tch_q, tch_d;
    logic signed [R-1:0]    lvl_q, lvl_d;
    logic signed [R-1:0]    prev_q, prev_d;
    logic                   fpend_q, fpend_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [W-1:0]           rd_data_q;

    logic [CW-1:0]          n_clamp_c;
    logic [CW-1:0]          post_len_c;
    logic signed [R-1:0]    cur_c;
    logic                   trig_c;
    logic                   accept_c;
    logic                   we_c;
    logic [DEPTH_LOG2-1:0]  waddr_c;

    logic [W-1:0]           mem [DEPTH];

`ifdef ADC_CAPTURE_PRETRIG_EN
    logic [DEPTH_LOG2-1:0]  pre_lat_q, pre_lat_d;
    logic [DEPTH_LOG2-1:0]  wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]  trig_addr_q, trig_addr_d;
    logic [CW-1:0]          pre_cnt_q, pre_cnt_d;
    logic [DEPTH_LOG2-1:0]  pre_clamp_c;

    assign pre_clamp_c = (CW'(pretrig) >= n_clamp_c) ? DEPTH_LOG2'(n_clamp_c - CW'(1)) : pretrig;
    assign post_len_c  = n_lat_q - CW'(pre_lat_q);
    assign trig_addr   = trig_addr_q;
`else
    assign post_len_c  = n_lat_q;
`endif

    // Out-of-range capture lengths (0 or beyond the RAM) mean "fill the whole RAM".
    assign n_clamp_c = ((n_samples == '0) || (n_samples > CW'(DEPTH))) ? CW'(DEPTH) : n_samples;

    assign state    = state_q;
    assign wr_count = wr_count_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        n_lat_d    = n_lat_q;
        tch_d      = tch_q;
        lvl_d      = lvl_q;
        prev_d     = prev_q;
        fpend_d    = fpend_q;
        rd_valid_d = rd_en;
        we_c       = 1'b0;
        waddr_c    = '0;
`ifdef ADC_CAPTURE_PRETRIG_EN
        pre_lat_d   = pre_lat_q;
        wptr_d      = wptr_q;
        trig_addr_d = trig_addr_q;
        pre_cnt_d   = pre_cnt_q;
`endif
        cur_c  = in_data[32'(tch_q) * R +: R];
        trig_c = in_valid && (fpend_q || force_trig || ((prev_q < lvl_q) && (cur_c >= lvl_q)));
`ifdef ADC_CAPTURE_PRETRIG_EN
        accept_c = trig_c && (pre_cnt_q >= CW'(pre_lat_q));
`else
        accept_c = trig_c;
`endif

        case (state_q)
            S_ARMED: begin
                if (force_trig) begin
                    fpend_d = 1'b1;
                end
                if (in_valid) begin
                    prev_d = cur_c;
`ifdef ADC_CAPTURE_PRETRIG_EN
                    // Every armed sample lands in the circular buffer, trigger or not.
                    we_c    = 1'b1;
                    waddr_c = wptr_q;
                    wptr_d  = wptr_q + 1'b1;
                    if (pre_cnt_q != CW'(DEPTH)) begin
                        pre_cnt_d = pre_cnt_q + CW'(1);
                    end
                    if (accept_c) begin
                        trig_addr_d = wptr_q;
                    end
`else
                    we_c = accept_c;
`endif
                    if (accept_c) begin
                        fpend_d    = 1'b0;
                        wr_count_d = CW'(1);
                        state_d    = (post_len_c == CW'(1)) ? S_DONE : S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    we_c = 1'b1;
`ifdef ADC_CAPTURE_PRETRIG_EN
                    waddr_c = trig_addr_q + wr_count_q[DEPTH_LOG2-1:0];
`else
                    waddr_c = wr_count_q[DEPTH_LOG2-1:0];
`endif
                    wr_count_d = wr_count_q + CW'(1);
                    if ((wr_count_q + CW'(1)) == post_len_c) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: ;
        endcase

        // Control pulses override the datapath; abort has priority over arm.
        if (abort) begin
            state_d    = S_IDLE;
            wr_count_d = wr_count_q;
            fpend_d    = 1'b0;
            we_c       = 1'b0;
`ifdef ADC_CAPTURE_PRETRIG_EN
            trig_addr_d = trig_addr_q;
`endif
        end else if (arm) begin
            state_d    = S_ARMED;
            wr_count_d = '0;
            n_lat_d    = n_clamp_c;
            tch_d      = trig_ch;
            lvl_d      = trig_level;
            prev_d     = '0;
            fpend_d    = 1'b0;
            we_c       = 1'b0;
`ifdef ADC_CAPTURE_PRETRIG_EN
            pre_lat_d   = pre_clamp_c;
            pre_cnt_d   = '0;
            wptr_d      = '0;
            trig_addr_d = trig_addr_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_count_q <= '0;
            n_lat_q    <= CW'(DEPTH);
            tch_q      <= '0;
            lvl_q      <= '0;
            prev_q     <= '0;
            fpend_q    <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef ADC_CAPTURE_PRETRIG_EN
            pre_lat_q   <= '0;
            wptr_q      <= '0;
            trig_addr_q <= '0;
            pre_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            n_lat_q    <= n_lat_d;
            tch_q      <= tch_d;
            lvl_q      <= lvl_d;
            prev_q     <= prev_d;
            fpend_q    <= fpend_d;
            rd_valid_q <= rd_valid_d;
`ifdef ADC_CAPTURE_PRETRIG_EN
            pre_lat_q   <= pre_lat_d;
            wptr_q      <= wptr_d;
            trig_addr_q <= trig_addr_d;
            pre_cnt_q   <= pre_cnt_d;
`endif
        end
    end

    // Capture RAM: write port from the sample path, contents survive reset.
    always_ff @(posedge clk) begin
        if (we_c && !reset) begin
            mem[waddr_c] <= in_data;
        end
    end

    // Registered read; same-address write in the same cycle returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

endmodule
